// File: rtl/usb_slavefifo_tx.sv
// usb_slavefifo_tx: streams 16-bit upstream words into a USB controller's
// slave FIFO (IN endpoint). Whole packets commit automatically when the
// FIFO fills to PKT_WORDS words. A partial packet is committed with PKTEND,
// either on a flush request or after IDLE_FLUSH idle cycles.
//
// Ports
//   clk, rst_n             interface clock, async active-low reset
//   usb_ready              USB chip out of reset (level)
//   data_in/data_valid     upstream word and valid
//   data_ready             word accepted this cycle (combinational)
//   flush                  request to commit a partial packet
//   full_n                 slave FIFO full flag (low = full)
//   fd, slwr_n, pktend_n   FIFO data bus, write strobe, packet-end strobe
//   fifoadr                endpoint select (constant EP_ADDR)
//   sloe_n, slrd_n         read side, tied inactive
//   word_cnt               total words written, wrapping
module usb_slavefifo_tx #(
  parameter int unsigned PKT_WORDS  = 256,
  parameter int unsigned IDLE_FLUSH = 4096,
  parameter logic [1:0]  EP_ADDR    = 2'b10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        usb_ready,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic        flush,
  input  logic        full_n,
  output logic [15:0] fd,
  output logic        slwr_n,
  output logic        pktend_n,
  output logic [1:0]  fifoadr,
  output logic        sloe_n,
  output logic        slrd_n,
  output logic [15:0] word_cnt
);

  localparam int unsigned PKT_W  = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int unsigned IDLE_W = 16;
  localparam logic [PKT_W-1:0]  PKT_LAST  = PKT_W'(PKT_WORDS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_FLUSH - 1);

  typedef enum logic [1:0] {
    WAIT_RDY = 2'd0,
    WRITE    = 2'd1,
    STALL    = 2'd2,
    PKTEND   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PKT_W-1:0]   pkt_cnt, pkt_cnt_d;
  logic [IDLE_W-1:0]  idle_cnt, idle_cnt_d;
  logic               slwr_n_d, pktend_n_d;
  logic               accept;

  // Handshake is a pure function of state and the two USB-side flags.
  assign data_ready = (state_q == WRITE) & full_n & usb_ready;
  assign accept     = data_valid & data_ready;

  // Static read-side / address pins.
  assign fifoadr = EP_ADDR;
  assign sloe_n  = 1'b1;
  assign slrd_n  = 1'b1;

  // Next state, packet/idle counters and strobe values.
  always_comb begin
    state_d    = state_q;
    pkt_cnt_d  = pkt_cnt;
    idle_cnt_d = idle_cnt;
    slwr_n_d   = 1'b1;
    pktend_n_d = 1'b1;

    if (!usb_ready) begin
      // Losing the USB chip abandons the partial packet bookkeeping.
      state_d    = WAIT_RDY;
      pkt_cnt_d  = '0;
      idle_cnt_d = '0;
    end else begin
      case (state_q)
        WAIT_RDY: state_d = WRITE;
        WRITE: begin
          if (accept) begin
            // Accept beats a same-cycle flush; the FIFO commits at the wrap itself.
            slwr_n_d   = 1'b0;
            pkt_cnt_d  = (pkt_cnt == PKT_LAST) ? '0 : pkt_cnt + PKT_W'(1);
            idle_cnt_d = '0;
          end else if (!full_n) begin
            state_d = STALL;
          end else if (pkt_cnt != '0 && (flush || idle_cnt >= IDLE_LAST)) begin
            state_d    = PKTEND;
            pktend_n_d = 1'b0;
          end else if (pkt_cnt != '0) begin
            idle_cnt_d = idle_cnt + IDLE_W'(1);
          end
        end
        STALL: begin
          if (full_n) state_d = WRITE;
        end
        PKTEND: begin
          state_d    = WRITE;
          pkt_cnt_d  = '0;
          idle_cnt_d = '0;
        end
        default: state_d = WAIT_RDY;
      endcase
    end
  end

  // State and registered FIFO-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_RDY;
      pkt_cnt  <= '0;
      idle_cnt <= '0;
      fd       <= '0;
      slwr_n   <= 1'b1;
      pktend_n <= 1'b1;
      word_cnt <= '0;
    end else begin
      state_q  <= state_d;
      pkt_cnt  <= pkt_cnt_d;
      idle_cnt <= idle_cnt_d;
      slwr_n   <= slwr_n_d;
      pktend_n <= pktend_n_d;
      if (accept) begin
        fd       <= data_in;
        word_cnt <= word_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_usb_slavefifo_tx.sv
// Testbench for usb_slavefifo_tx: directed stimulus pushes expected FIFO
// writes and packet-ends into a queue; a negedge monitor pops and compares
// each strobe it sees on slwr_n / pktend_n.
module tb_usb_slavefifo_tx;

  localparam int unsigned PKT_WORDS  = 256;
  localparam int unsigned IDLE_FLUSH = 16;
  localparam logic [1:0]  EP_ADDR    = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        usb_ready;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic        flush;
  logic        full_n;
  logic [15:0] fd;
  logic        slwr_n;
  logic        pktend_n;
  logic [1:0]  fifoadr;
  logic        sloe_n;
  logic        slrd_n;
  logic [15:0] word_cnt;

  usb_slavefifo_tx #(
    .PKT_WORDS (PKT_WORDS),
    .IDLE_FLUSH(IDLE_FLUSH),
    .EP_ADDR   (EP_ADDR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .usb_ready (usb_ready),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .flush     (flush),
    .full_n    (full_n),
    .fd        (fd),
    .slwr_n    (slwr_n),
    .pktend_n  (pktend_n),
    .fifoadr   (fifoadr),
    .sloe_n    (sloe_n),
    .slrd_n    (slrd_n),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_end;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   wr_count    = 0;
  int   end_count   = 0;
  int   last_wr_cyc = 0;
  int   last_end_cyc = 0;
  int   exp_wc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Scoreboard monitor: every strobe must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (!slwr_n || !pktend_n)
        chk("strobe_exclusive", 32'(slwr_n ^ pktend_n), 32'd1);
      if (!slwr_n) begin
        wr_count++;
        last_wr_cyc = cyc;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = '{is_end: 1'b1, data: 16'hDEAD};
        chk("fifo_write", 32'({1'b0, fd}), 32'(e));
      end
      if (!pktend_n) begin
        end_count++;
        last_end_cyc = cyc;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = '{is_end: 1'b0, data: 16'hDEAD};
        chk("pktend", 32'({~pktend_n, 16'h0000}), 32'(e));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one word and hold it until accepted (bounded).
  task automatic send(input logic [15:0] w);
    int n;
    n = 0;
    exp_q.push_back('{is_end: 1'b0, data: w});
    exp_wc++;
    data_in    = w;
    data_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (data_ready) break;
      n++;
      if (n >= 1000) begin
        chk("send_timeout", 32'(data_ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic expect_end();
    exp_q.push_back('{is_end: 1'b1, data: 16'h0000});
  endtask

  task automatic wait_drain(input string nm, input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    tick(2);
    rst_n  = 1'b1;
    exp_wc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int raise_cyc, e0, e1, wc0, wr0;
    rst_n      = 1'b0;
    usb_ready  = 1'b0;
    data_valid = 1'b0;
    data_in    = 16'h0000;
    flush      = 1'b0;
    full_n     = 1'b1;

    // Reset state
    #12;
    chk("rst_slwr_n",     32'(slwr_n),     32'd1);
    chk("rst_pktend_n",   32'(pktend_n),   32'd1);
    chk("rst_data_ready", 32'(data_ready), 32'd0);
    chk("rst_word_cnt",   32'(word_cnt),   32'd0);
    chk("rst_fd",         32'(fd),         32'd0);
    chk("rst_fifoadr",    32'(fifoadr),    32'(EP_ADDR));
    chk("rst_sloe_n",     32'(sloe_n),     32'd1);
    chk("rst_slrd_n",     32'(slrd_n),     32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);
    chk("fifoadr_after_rst", 32'(fifoadr), 32'(EP_ADDR));

    // Held word while USB chip not ready, then release
    data_in    = 16'hA5A5;
    data_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("notready_data_ready", 32'(data_ready), 32'd0);
      chk("notready_slwr_n",     32'(slwr_n),     32'd1);
    end
    @(posedge clk);
    #1 usb_ready = 1'b1;
    raise_cyc = cyc;
    send(16'hA5A5);
    @(negedge clk);
    #1;
    chk("first_strobe_latency", 32'(last_wr_cyc), 32'(raise_cyc + 2));
    expect_end();
    wait_drain("single_word_idle_flush", 40);

    // 512-word stream, two auto-committed packets
    pulse_reset();
    wr0 = wr_count;
    e0  = end_count;
    for (int i = 0; i < 512; i++) send(16'(i * 3 + 7));
    tick(3);
    wait_drain("stream_drain", 10);
    chk("stream_strobes",  32'(wr_count - wr0), 32'd512);
    chk("stream_word_cnt", 32'(word_cnt),       32'd512);
    tick(30);
    chk("stream_no_pktend", 32'(end_count - e0), 32'd0);

    // Full flag after word 100 for 20 cycles
    e0 = end_count;
    for (int i = 0; i < 100; i++) send(16'h1000 + 16'(i));
    full_n     = 1'b0;
    data_in    = 16'h1064;
    data_valid = 1'b1;
    @(negedge clk);
    #1;
    wc0 = wr_count;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_data_ready", 32'(data_ready), 32'd0);
    end
    #1;
    chk("stall_no_strobe", 32'(wr_count - wc0), 32'd0);
    @(posedge clk);
    #1 full_n = 1'b1;
    for (int i = 100; i < 256; i++) send(16'h1000 + 16'(i));
    tick(3);
    wait_drain("stall_drain", 10);
    chk("stall_word_cnt", 32'(word_cnt), 32'(exp_wc));
    tick(25);
    chk("stall_no_pktend", 32'(end_count - e0), 32'd0);

    // Idle flush of a 10-word partial packet
    e0 = end_count;
    for (int i = 0; i < 10; i++) send(16'h2000 + 16'(i));
    expect_end();
    for (int i = 0; i < 40 && end_count == e0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("idle_pktend_seen", 32'(end_count - e0), 32'd1);
    chk("idle_pktend_gap",  32'(last_end_cyc - last_wr_cyc), 32'(IDLE_FLUSH));
    @(posedge clk);
    #1 flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(10);
    chk("idle_then_flush_ignored", 32'(end_count - e0), 32'd1);

    // Flush coinciding with accept, then held one more cycle
    e0 = end_count;
    for (int i = 0; i < 3; i++) send(16'h3000 + 16'(i));
    exp_q.push_back('{is_end: 1'b0, data: 16'h3003});
    exp_wc++;
    expect_end();
    data_in    = 16'h3003;
    data_valid = 1'b1;
    flush      = 1'b1;
    @(negedge clk);
    chk("flush_accept_ready", 32'(data_ready), 32'd1);
    @(posedge clk);
    #1 data_valid = 1'b0;
    tick(1);
    flush = 1'b0;
    wait_drain("flush_drain", 10);
    chk("flush_pktend_count", 32'(end_count - e0), 32'd1);
    chk("flush_pktend_gap",   32'(last_end_cyc - last_wr_cyc), 32'd1);
    e1 = end_count;
    @(posedge clk);
    #1 flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(10);
    chk("flush_empty_ignored", 32'(end_count - e1), 32'd0);

    // usb_ready drop mid-packet
    e0 = end_count;
    for (int i = 0; i < 5; i++) send(16'h4000 + 16'(i));
    usb_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("drop_data_ready", 32'(data_ready), 32'd0);
    tick(1);
    @(negedge clk);
    chk("drop_slwr_n",   32'(slwr_n),   32'd1);
    chk("drop_pktend_n", 32'(pktend_n), 32'd1);
    tick(25);
    chk("drop_no_pktend", 32'(end_count - e0), 32'd0);
    usb_ready = 1'b1;
    for (int i = 0; i < 256; i++) send(16'h5000 + 16'(i));
    tick(25);
    wait_drain("drop_drain", 10);
    chk("drop_fresh_packet", 32'(end_count - e0), 32'd0);
    chk("drop_word_cnt", 32'(word_cnt), 32'(exp_wc));

    // Asynchronous reset mid-packet
    e0 = end_count;
    for (int i = 0; i < 5; i++) send(16'h6000 + 16'(i));
    data_in    = 16'h6005;
    data_valid = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_slwr_n",     32'(slwr_n),     32'd1);
    chk("arst_pktend_n",   32'(pktend_n),   32'd1);
    chk("arst_word_cnt",   32'(word_cnt),   32'd0);
    chk("arst_fd",         32'(fd),         32'd0);
    chk("arst_data_ready", 32'(data_ready), 32'd0);
    data_valid = 1'b0;
    exp_wc     = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 256; i++) send(16'h7000 + 16'(i));
    tick(25);
    wait_drain("arst_drain", 10);
    chk("arst_fresh_packet", 32'(end_count - e0), 32'd0);
    chk("arst_word_cnt_after", 32'(word_cnt), 32'd256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usb_slavefifo_tx.md
USB_SLAVEFIFO_TX -- requirements
Module: usb_slavefifo_tx

Interface
REQ-001 Parameter PKT_WORDS, default 256, meaning 16-bit words per USB bulk packet; auto-commit boundary, power of two, 2..1024.
REQ-002 Parameter IDLE_FLUSH, default 4096, meaning idle cycles with a partial packet before a forced PKTEND; range 2..65535.
REQ-003 Parameter EP_ADDR, default 2'b10, meaning FIFOADR value driven for the IN endpoint.
REQ-004 clk  input  1  interface clock (IFCLK domain); all logic rises on posedge clk.
REQ-005 rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-006 usb_ready  input  1  high once the USB chip has been released from reset; level, synchronous to clk.
REQ-007 data_in  input  16  upstream word.
REQ-008 data_valid  input  1  upstream word present.
REQ-009 data_ready  output  1  block accepts data_in this cycle.
REQ-010 flush  input  1  single-cycle request to commit a partial packet.
REQ-011 full_n  input  1  slave FIFO full flag, low = full, synchronous to clk.
REQ-012 fd  output  16  slave FIFO data bus, write-only.
REQ-013 slwr_n  output  1  FIFO write strobe, active-low.
REQ-014 pktend_n  output  1  packet-end strobe, active-low.
REQ-015 fifoadr  output  2  endpoint select, constant EP_ADDR after reset.
REQ-016 sloe_n, slrd_n  output  1 each  tied high; no reads are issued.
REQ-017 word_cnt  output  16  total words written, wraps 0xFFFF->0.

Function
REQ-018 States SHALL be WAIT_RDY, WRITE, STALL, PKTEND.
REQ-019 WAIT_RDY: data_ready=0; usb_ready=1 -> WRITE on the next edge.
REQ-020 Accept = data_valid & data_ready; data_ready = (state==WRITE) & full_n & usb_ready.
REQ-021 On accept, fd SHALL be registered to data_in and slwr_n driven low on the next cycle only, giving one-cycle latency; slwr_n is otherwise high.
REQ-022 Internal pkt_cnt SHALL increment per accept and wrap PKT_WORDS-1 -> 0; the FIFO auto-commits at the wrap, so no PKTEND is issued at the boundary.
REQ-023 WRITE with full_n=0 SHALL go to STALL; STALL returns to WRITE when full_n=1; no strobes are issued in STALL.
REQ-024 Idle counter: reset on accept, else increment in WRITE while pkt_cnt!=0; at IDLE_FLUSH-1 it forces PKTEND.
REQ-025 flush=1 in WRITE with pkt_cnt!=0 SHALL go to PKTEND; flush with pkt_cnt==0 is ignored; flush outside WRITE is dropped.
REQ-026 PKTEND: one cycle, pktend_n=0, data_ready=0, slwr_n high; pkt_cnt and idle counter cleared; next state WRITE.
REQ-027 If flush and accept are both asserted in the same cycle, the accept SHALL win; the flush is honored in the following cycle if flush is still held, else dropped.
REQ-028 usb_ready falling in any state SHALL return the block to WAIT_RDY on the next edge, clear pkt_cnt and the idle counter, and drive slwr_n and pktend_n high; data already strobed is not retracted.
REQ-029 slwr_n and pktend_n SHALL never be low in the same cycle.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state=WAIT_RDY, fd=0, slwr_n=1, pktend_n=1, data_ready=0, word_cnt=0, pkt_cnt=0, and idle counter=0.
REQ-031 fifoadr=EP_ADDR, sloe_n=1, and slrd_n=1 SHALL hold during and after reset.
REQ-032 Reset deassertion SHALL take effect on the first posedge clk with rst_n=1; no transfer starts until usb_ready=1.

Verification
REQ-033 usb_ready=0 with data_valid held -> data_ready=0 and slwr_n=1 throughout; raise usb_ready -> first slwr_n low 2 cycles later with fd = the held word.
REQ-034 Stream 512 words, PKT_WORDS=256, full_n=1 -> 512 slwr_n pulses, pktend_n never low, word_cnt=512.
REQ-035 full_n=0 after word 100 for 20 cycles -> no strobe while full, resume on word 101, no word lost or duplicated.
REQ-036 10 words, then data_valid=0, IDLE_FLUSH=16 -> single pktend_n pulse 16 cycles after the last accept; pkt_cnt=0 after it.
REQ-037 flush and accept in the same cycle, then flush again -> word written, then pktend_n pulse; flush with pkt_cnt=0 -> no pulse.
REQ-038 Drop usb_ready mid-packet, and separately assert rst_n=0 mid-packet -> strobes high immediately, the block re-enters WAIT_RDY, and the next packet starts at pkt_cnt=0.
